cp0_access_arbiter: RTL and testbench

- Sole master of the CP0 register file's write/read port.
- Arbitrates among three requesters: exception/ERET commit, MEM-stage MTC0/MFC0, and the TLB unit (TLBP/TLBR result write-back).
- Latches the winner's payload and drives the register file's multi-cycle wen/ren handshake until ready.
- Sequences TLBR into three back-to-back MTC0 writes.

---
 rtl/cp0_access_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_cp0_access_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0_access_arbiter.sv
// Single owner of the CP0 register-file port: arbitrates exception commit, pipeline MTC0/MFC0
// and TLB write-back, runs the wen/ren-until-ready handshake and expands TLBR into three writes.
// cp0_op_t encoding: NONE=0 EXC=1 BADVA=2 TLB=3 ERET=4 MTC0=5.
// exc_info_t packing: {epc[69:38], bd[37], exccode[36:32], badvaddr[31:0]}.
module cp0_access_arbiter #(
    parameter int WDOG_CYCLES = 16,
    parameter int TLBR_STEPS  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic [2:0]  exc_type,
    input  logic [69:0] exc_info_in,
    output logic        exc_ack,
    input  logic        pipe_req,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [2:0]  pipe_sel,
    input  logic [31:0] pipe_wdata,
    output logic        pipe_ack,
    output logic [31:0] pipe_rdata,
    input  logic        tlb_req,
    input  logic        tlb_op,
    input  logic [31:0] tlb_index,
    input  logic [31:0] tlb_entryhi,
    input  logic [31:0] tlb_entrylo0,
    input  logic [31:0] tlb_entrylo1,
    output logic        tlb_ack,
    output logic        cp0_wen,
    output logic        cp0_ren,
    output logic [2:0]  cp0_wtype,
    output logic [69:0] cp0_exc_info,
    output logic [4:0]  cp0_waddr,
    output logic [2:0]  cp0_wsel,
    output logic [31:0] cp0_wdata,
    output logic [4:0]  cp0_raddr,
    output logic [2:0]  cp0_rsel,
    input  logic        cp0_ready,
    input  logic [31:0] cp0_rdata,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_MTC0 = 3'd5;
    localparam logic [1:0] SRC_EXC  = 2'd0;
    localparam logic [1:0] SRC_PIPE = 2'd1;
    localparam logic [1:0] SRC_TLB  = 2'd2;
    localparam int WDW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG_CYCLES - 1);
    localparam logic [1:0] STEP_LAST = 2'(TLBR_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_TSEQ  = 2'd3
    } state_t;

    state_t state_r, state_s;
    logic [1:0]     step_r, step_s;
    logic [WDW-1:0] wdog_r, wdog_s;
    logic [1:0]     src_r, src_s;
    logic [31:0]    lo0_r, lo0_s, lo1_r, lo1_s;
    logic           err_r, err_s;
    logic           exc_ack_r, exc_ack_s, pipe_ack_r, pipe_ack_s, tlb_ack_r, tlb_ack_s;
    logic [31:0]    rdata_r, rdata_s;
    logic           wen_r, wen_s, ren_r, ren_s;
    logic [2:0]     wtype_r, wtype_s;
    logic [69:0]    info_r, info_s;
    logic [4:0]     waddr_r, waddr_s, raddr_r, raddr_s;
    logic [2:0]     wsel_r, wsel_s, rsel_r, rsel_s;
    logic [31:0]    wdata_r, wdata_s;
    logic           ack_any_s;

    // TLBR write order: EntryHi (10), EntryLo0 (2), EntryLo1 (3), all select 0.
    function automatic logic [4:0] tseq_reg(input logic [1:0] step);
        case (step)
            2'd0:    tseq_reg = 5'd10;
            2'd1:    tseq_reg = 5'd2;
            2'd2:    tseq_reg = 5'd3;
            default: tseq_reg = 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] tseq_data(input logic [1:0] step, input logic [31:0] lo0,
                                              input logic [31:0] lo1);
        case (step)
            2'd1:    tseq_data = lo0;
            2'd2:    tseq_data = lo1;
            default: tseq_data = 32'h0000_0000;
        endcase
    endfunction

    // Next-state, arbitration, handshake and watchdog logic.
    always_comb begin
        state_s    = state_r;
        step_s     = step_r;
        wdog_s     = wdog_r;
        src_s      = src_r;
        lo0_s      = lo0_r;
        lo1_s      = lo1_r;
        err_s      = err_r;
        exc_ack_s  = 1'b0;
        pipe_ack_s = 1'b0;
        tlb_ack_s  = 1'b0;
        rdata_s    = rdata_r;
        wen_s      = wen_r;
        ren_s      = ren_r;
        wtype_s    = wtype_r;
        info_s     = info_r;
        waddr_s    = waddr_r;
        wsel_s     = wsel_r;
        wdata_s    = wdata_r;
        raddr_s    = raddr_r;
        rsel_s     = rsel_r;
        ack_any_s  = exc_ack_r | pipe_ack_r | tlb_ack_r;

        case (state_r)
            ST_IDLE: begin
                wdog_s = {WDW{1'b0}};
                step_s = 2'd0;
                // Masking on ack keeps a requester that is about to drop req from being regranted.
                if (!ack_any_s && exc_req) begin
                    state_s = ST_WRITE;
                    src_s   = SRC_EXC;
                    wen_s   = 1'b1;
                    wtype_s = exc_type;
                    info_s  = exc_info_in;
                    waddr_s = 5'd0;
                    wsel_s  = 3'd0;
                    wdata_s = 32'h0000_0000;
                end else if (!ack_any_s && tlb_req) begin
                    src_s   = SRC_TLB;
                    wen_s   = 1'b1;
                    wtype_s = OP_MTC0;
                    wsel_s  = 3'd0;
                    if (tlb_op) begin
                        state_s = ST_TSEQ;
                        lo0_s   = tlb_entrylo0;
                        lo1_s   = tlb_entrylo1;
                        waddr_s = tseq_reg(2'd0);
                        wdata_s = tlb_entryhi;
                    end else begin
                        state_s = ST_WRITE;
                        waddr_s = 5'd0;
                        wdata_s = tlb_index;
                    end
                end else if (!ack_any_s && pipe_req) begin
                    src_s = SRC_PIPE;
                    if (pipe_we) begin
                        state_s = ST_WRITE;
                        wen_s   = 1'b1;
                        wtype_s = OP_MTC0;
                        waddr_s = pipe_addr;
                        wsel_s  = pipe_sel;
                        wdata_s = pipe_wdata;
                    end else begin
                        state_s = ST_READ;
                        ren_s   = 1'b1;
                        wtype_s = OP_NONE;
                        raddr_s = pipe_addr;
                        rsel_s  = pipe_sel;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (cp0_ready) begin
                    state_s    = ST_IDLE;
                    wen_s      = 1'b0;
                    wtype_s    = OP_NONE;
                    wdog_s     = {WDW{1'b0}};
                    exc_ack_s  = (src_r == SRC_EXC);
                    pipe_ack_s = (src_r == SRC_PIPE);
                    tlb_ack_s  = (src_r == SRC_TLB);
                end else if (wdog_r == WDOG_LAST) begin
                    state_s = ST_IDLE;
                    wen_s   = 1'b0;
                    wtype_s = OP_NONE;
                    wdog_s  = {WDW{1'b0}};
                    err_s   = 1'b1;
                end else begin
                    wdog_s = wdog_r + {{(WDW-1){1'b0}}, 1'b1};
                end
            end
            ST_READ: begin
                if (cp0_ready) begin
                    state_s    = ST_IDLE;
                    ren_s      = 1'b0;
                    wdog_s     = {WDW{1'b0}};
                    rdata_s    = cp0_rdata;
                    pipe_ack_s = 1'b1;
                end else if (wdog_r == WDOG_LAST) begin
                    state_s = ST_IDLE;
                    ren_s   = 1'b0;
                    wdog_s  = {WDW{1'b0}};
                    err_s   = 1'b1;
                end else begin
                    wdog_s = wdog_r + {{(WDW-1){1'b0}}, 1'b1};
                end
            end
            ST_TSEQ: begin
                if (cp0_ready && (step_r == STEP_LAST)) begin
                    state_s   = ST_IDLE;
                    wen_s     = 1'b0;
                    wtype_s   = OP_NONE;
                    step_s    = 2'd0;
                    wdog_s    = {WDW{1'b0}};
                    tlb_ack_s = 1'b1;
                end else if (cp0_ready) begin
                    step_s  = step_r + 2'd1;
                    waddr_s = tseq_reg(step_r + 2'd1);
                    wdata_s = tseq_data(step_r + 2'd1, lo0_r, lo1_r);
                    wdog_s  = {WDW{1'b0}};
                end else if (wdog_r == WDOG_LAST) begin
                    state_s = ST_IDLE;
                    wen_s   = 1'b0;
                    wtype_s = OP_NONE;
                    step_s  = 2'd0;
                    wdog_s  = {WDW{1'b0}};
                    err_s   = 1'b1;
                end else begin
                    wdog_s = wdog_r + {{(WDW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = ST_IDLE;
                wen_s   = 1'b0;
                ren_s   = 1'b0;
                wtype_s = OP_NONE;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            step_r     <= 2'd0;
            wdog_r     <= {WDW{1'b0}};
            src_r      <= SRC_EXC;
            lo0_r      <= 32'h0000_0000;
            lo1_r      <= 32'h0000_0000;
            err_r      <= 1'b0;
            exc_ack_r  <= 1'b0;
            pipe_ack_r <= 1'b0;
            tlb_ack_r  <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            wen_r      <= 1'b0;
            ren_r      <= 1'b0;
            wtype_r    <= OP_NONE;
            info_r     <= 70'd0;
            waddr_r    <= 5'd0;
            wsel_r     <= 3'd0;
            wdata_r    <= 32'h0000_0000;
            raddr_r    <= 5'd0;
            rsel_r     <= 3'd0;
        end else begin
            state_r    <= state_s;
            step_r     <= step_s;
            wdog_r     <= wdog_s;
            src_r      <= src_s;
            lo0_r      <= lo0_s;
            lo1_r      <= lo1_s;
            err_r      <= err_s;
            exc_ack_r  <= exc_ack_s;
            pipe_ack_r <= pipe_ack_s;
            tlb_ack_r  <= tlb_ack_s;
            rdata_r    <= rdata_s;
            wen_r      <= wen_s;
            ren_r      <= ren_s;
            wtype_r    <= wtype_s;
            info_r     <= info_s;
            waddr_r    <= waddr_s;
            wsel_r     <= wsel_s;
            wdata_r    <= wdata_s;
            raddr_r    <= raddr_s;
            rsel_r     <= rsel_s;
        end
    end

    assign exc_ack      = exc_ack_r;
    assign pipe_ack     = pipe_ack_r;
    assign tlb_ack      = tlb_ack_r;
    assign pipe_rdata   = rdata_r;
    assign cp0_wen      = wen_r;
    assign cp0_ren      = ren_r;
    assign cp0_wtype    = wtype_r;
    assign cp0_exc_info = info_r;
    assign cp0_waddr    = waddr_r;
    assign cp0_wsel     = wsel_r;
    assign cp0_wdata    = wdata_r;
    assign cp0_raddr    = raddr_r;
    assign cp0_rsel     = rsel_r;
    assign err          = err_r;
    assign busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_cp0_access_arbiter.sv
// Directed bench for cp0_access_arbiter with a register-file model that raises ready
// on the 3rd wen cycle / 2nd ren cycle of each access, optionally withheld.
module tb_cp0_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exc_req, pipe_req, pipe_we, tlb_req, tlb_op;
    logic [2:0]  exc_type, pipe_sel;
    logic [69:0] exc_info_in;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_wdata, tlb_index, tlb_entryhi, tlb_entrylo0, tlb_entrylo1;
    logic        exc_ack, pipe_ack, tlb_ack, cp0_wen, cp0_ren, busy, err;
    logic [31:0] pipe_rdata, cp0_wdata, rf_rdata;
    logic [2:0]  cp0_wtype, cp0_wsel, cp0_rsel;
    logic [69:0] cp0_exc_info;
    logic [4:0]  cp0_waddr, cp0_raddr;
    logic        cp0_ready;
    logic        rf_hold;
    logic [7:0]  rf_cnt = 8'd0;

    int checks = 0;
    int errors = 0;
    int cyc, wen_cnt, ren_cnt, busy_cnt, first_ren, nlog;
    int exc_acks, pipe_acks, tlb_acks, exc_ack_at, pipe_ack_at, tlb_ack_at;
    logic [4:0]  wa_log [8];
    logic [31:0] wd_log [8];
    logic [2:0]  wt_log [8];
    logic [69:0] info_seen;
    logic [4:0]  raddr_seen;
    logic [31:0] rdata_at_ack;

    cp0_access_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .exc_req(exc_req), .exc_type(exc_type), .exc_info_in(exc_info_in), .exc_ack(exc_ack),
        .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_sel(pipe_sel),
        .pipe_wdata(pipe_wdata), .pipe_ack(pipe_ack), .pipe_rdata(pipe_rdata),
        .tlb_req(tlb_req), .tlb_op(tlb_op), .tlb_index(tlb_index), .tlb_entryhi(tlb_entryhi),
        .tlb_entrylo0(tlb_entrylo0), .tlb_entrylo1(tlb_entrylo1), .tlb_ack(tlb_ack),
        .cp0_wen(cp0_wen), .cp0_ren(cp0_ren), .cp0_wtype(cp0_wtype), .cp0_exc_info(cp0_exc_info),
        .cp0_waddr(cp0_waddr), .cp0_wsel(cp0_wsel), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rsel(cp0_rsel), .cp0_ready(cp0_ready), .cp0_rdata(rf_rdata),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (!(cp0_wen || cp0_ren) || cp0_ready) rf_cnt <= 8'd0;
        else                                    rf_cnt <= rf_cnt + 8'd1;
    end
    assign cp0_ready = !rf_hold && ((cp0_wen && rf_cnt == 8'd2) || (cp0_ren && rf_cnt == 8'd1));

    task automatic clear_mon();
        cyc = 0; wen_cnt = 0; ren_cnt = 0; busy_cnt = 0; first_ren = -1; nlog = 0;
        exc_acks = 0; pipe_acks = 0; tlb_acks = 0;
        exc_ack_at = -1; pipe_ack_at = -1; tlb_ack_at = -1;
        info_seen = 70'd0; raddr_seen = 5'd0; rdata_at_ack = 32'h0;
    endtask

    // One cycle: sample at the falling edge, log activity, drop requests once acked.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (cp0_wen) wen_cnt++;
        if (cp0_ren) begin
            ren_cnt++;
            raddr_seen = cp0_raddr;
            if (first_ren < 0) first_ren = cyc;
        end
        if (busy) busy_cnt++;
        if (cp0_wen && cp0_wtype == 3'd1) info_seen = cp0_exc_info;
        if (cp0_wen && cp0_ready && nlog < 8) begin
            wa_log[nlog] = cp0_waddr; wd_log[nlog] = cp0_wdata; wt_log[nlog] = cp0_wtype;
            nlog++;
        end
        if (exc_ack)  begin exc_acks++;  exc_ack_at = cyc;  exc_req = 1'b0; end
        if (pipe_ack) begin pipe_acks++; pipe_ack_at = cyc; pipe_req = 1'b0; rdata_at_ack = pipe_rdata; end
        if (tlb_ack)  begin tlb_acks++;  tlb_ack_at = cyc;  tlb_req = 1'b0; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({cp0_wen, cp0_ren, busy, err, exc_ack, pipe_ack, tlb_ack} !== 7'd0) begin
            errors++; $display("FAIL reset_held ctrl=%b expected 0", {cp0_wen, cp0_ren, busy, err, exc_ack, pipe_ack, tlb_ack}); end
        rst_n = 1'b1;
        clear_mon();
        repeat (10) tick();
        checks++; if (cp0_wtype !== 3'd0 || pipe_rdata !== 32'h0 || cp0_waddr !== 5'd0 || cp0_wdata !== 32'h0) begin
            errors++; $display("FAIL reset_outputs wtype=%0d rdata=%h waddr=%0d wdata=%h expected 0", cp0_wtype, pipe_rdata, cp0_waddr, cp0_wdata); end
        checks++; if (wen_cnt !== 0 || ren_cnt !== 0 || busy_cnt !== 0) begin
            errors++; $display("FAIL reset_idle wen=%0d ren=%0d busy=%0d expected 0", wen_cnt, ren_cnt, busy_cnt); end
    endtask

    task automatic test_mtc0();
        clear_mon();
        pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 5'd12; pipe_sel = 3'd0; pipe_wdata = 32'h0000FF03;
        repeat (8) tick();
        checks++; if (wen_cnt !== 3) begin errors++; $display("FAIL mtc0_wen_cycles got %0d expected 3", wen_cnt); end
        checks++; if (pipe_acks !== 1 || pipe_ack_at !== 4) begin
            errors++; $display("FAIL mtc0_ack count=%0d at=%0d expected 1 at 4", pipe_acks, pipe_ack_at); end
        checks++; if (nlog !== 1 || wa_log[0] !== 5'd12 || wd_log[0] !== 32'h0000FF03 || wt_log[0] !== 3'd5) begin
            errors++; $display("FAIL mtc0_payload n=%0d addr=%0d data=%h type=%0d expected 1/12/0000ff03/5", nlog, wa_log[0], wd_log[0], wt_log[0]); end
    endtask

    task automatic test_mfc0();
        clear_mon();
        rf_rdata = 32'h00018000;
        pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 5'd15; pipe_sel = 3'd0;
        repeat (8) tick();
        checks++; if (ren_cnt !== 2 || wen_cnt !== 0) begin
            errors++; $display("FAIL mfc0_cycles ren=%0d wen=%0d expected 2/0", ren_cnt, wen_cnt); end
        checks++; if (pipe_acks !== 1 || pipe_ack_at !== 3 || rdata_at_ack !== 32'h00018000) begin
            errors++; $display("FAIL mfc0_ack count=%0d at=%0d rdata=%h expected 1 at 3 00018000", pipe_acks, pipe_ack_at, rdata_at_ack); end
        checks++; if (raddr_seen !== 5'd15 || pipe_rdata !== 32'h00018000) begin
            errors++; $display("FAIL mfc0_hold raddr=%0d rdata=%h expected 15/00018000", raddr_seen, pipe_rdata); end
    endtask

    task automatic test_exc_vs_pipe();
        clear_mon();
        rf_rdata = 32'hCAFE0001;
        exc_req = 1'b1; exc_type = 3'd1; exc_info_in = {32'hBFC00100, 1'b0, 5'd0, 32'h0};
        pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 5'd15;
        repeat (14) tick();
        checks++; if (exc_acks !== 1 || exc_ack_at !== 4 || wen_cnt !== 3 || wt_log[0] !== 3'd1) begin
            errors++; $display("FAIL exc_first acks=%0d at=%0d wen=%0d type=%0d expected 1/4/3/1", exc_acks, exc_ack_at, wen_cnt, wt_log[0]); end
        checks++; if (info_seen[69:38] !== 32'hBFC00100) begin
            errors++; $display("FAIL exc_epc got %h expected bfc00100", info_seen[69:38]); end
        checks++; if (first_ren !== 6 || ren_cnt !== 2 || pipe_acks !== 1 || pipe_ack_at !== 8) begin
            errors++; $display("FAIL exc_then_pipe ren_at=%0d ren=%0d acks=%0d at=%0d expected 6/2/1/8", first_ren, ren_cnt, pipe_acks, pipe_ack_at); end
        checks++; if (pipe_rdata !== 32'hCAFE0001) begin
            errors++; $display("FAIL exc_pipe_rdata got %h expected cafe0001", pipe_rdata); end
    endtask

    task automatic test_tlbr();
        clear_mon();
        tlb_req = 1'b1; tlb_op = 1'b1;
        tlb_entryhi = 32'h12345000; tlb_entrylo0 = 32'h00000016; tlb_entrylo1 = 32'h00000017;
        repeat (14) tick();
        checks++; if (wen_cnt !== 9 || busy_cnt !== 9) begin
            errors++; $display("FAIL tlbr_cycles wen=%0d busy=%0d expected 9/9", wen_cnt, busy_cnt); end
        checks++; if (nlog !== 3 || wa_log[0] !== 5'd10 || wa_log[1] !== 5'd2 || wa_log[2] !== 5'd3) begin
            errors++; $display("FAIL tlbr_addr n=%0d seq=%0d,%0d,%0d expected 3: 10,2,3", nlog, wa_log[0], wa_log[1], wa_log[2]); end
        checks++; if (wd_log[0] !== 32'h12345000 || wd_log[1] !== 32'h00000016 || wd_log[2] !== 32'h00000017) begin
            errors++; $display("FAIL tlbr_data got %h,%h,%h expected 12345000,00000016,00000017", wd_log[0], wd_log[1], wd_log[2]); end
        checks++; if (tlb_acks !== 1 || tlb_ack_at !== 10) begin
            errors++; $display("FAIL tlbr_ack count=%0d at=%0d expected 1 at 10", tlb_acks, tlb_ack_at); end
    endtask

    task automatic test_watchdog();
        clear_mon();
        rf_hold = 1'b1;
        pipe_req = 1'b1; pipe_we = 1'b1; pipe_addr = 5'd12; pipe_wdata = 32'h000000A5;
        repeat (16) tick();
        checks++; if (cp0_wen !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL wdog_pending wen=%b err=%b expected 1/0", cp0_wen, err); end
        tick();
        checks++; if (cp0_wen !== 1'b0 || err !== 1'b1 || busy !== 1'b0 || pipe_acks !== 0) begin
            errors++; $display("FAIL wdog_trip wen=%b err=%b busy=%b acks=%0d expected 0/1/0/0", cp0_wen, err, busy, pipe_acks); end
        rf_hold = 1'b0;
        repeat (7) tick();
        checks++; if (wen_cnt !== 19 || pipe_acks !== 1 || pipe_ack_at !== 21 || err !== 1'b1) begin
            errors++; $display("FAIL wdog_regrant wen=%0d acks=%0d at=%0d err=%b expected 19/1/21/1", wen_cnt, pipe_acks, pipe_ack_at, err); end
    endtask

    task automatic test_reset_mid_tseq();
        clear_mon();
        tlb_req = 1'b1; tlb_op = 1'b1;
        repeat (5) tick();
        checks++; if (cp0_wen !== 1'b1 || cp0_waddr !== 5'd2) begin
            errors++; $display("FAIL tseq_mid wen=%b waddr=%0d expected 1/2", cp0_wen, cp0_waddr); end
        rst_n = 1'b0;
        #1;
        checks++; if (cp0_wen !== 1'b0 || busy !== 1'b0 || cp0_wtype !== 3'd0 || cp0_waddr !== 5'd0 || err !== 1'b0) begin
            errors++; $display("FAIL tseq_reset wen=%b busy=%b wtype=%0d waddr=%0d err=%b expected all 0", cp0_wen, busy, cp0_wtype, cp0_waddr, err); end
        tlb_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (5) tick();
        checks++; if (tlb_acks !== 0 || wen_cnt !== 0) begin
            errors++; $display("FAIL tseq_abandon acks=%0d wen=%0d expected 0/0", tlb_acks, wen_cnt); end
    endtask

    initial begin
        rst_n = 1'b0; rf_hold = 1'b0; rf_rdata = 32'h0;
        exc_req = 1'b0; exc_type = 3'd0; exc_info_in = 70'd0;
        pipe_req = 1'b0; pipe_we = 1'b0; pipe_addr = 5'd0; pipe_sel = 3'd0; pipe_wdata = 32'h0;
        tlb_req = 1'b0; tlb_op = 1'b0; tlb_index = 32'h0;
        tlb_entryhi = 32'h0; tlb_entrylo0 = 32'h0; tlb_entrylo1 = 32'h0;
        test_reset();
        test_mtc0();
        test_mfc0();
        test_exc_vs_pipe();
        test_tlbr();
        test_watchdog();
        test_reset_mid_tseq();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
